wb_decoder_3: RTL and testbench

Single-master to 3-slave Wishbone classic address decoder. It is the slave-side counterpart of the 3-port arbiter: the arbiter's wbs_* output feeds this block's wbm_* input. The decode is registered per cycle. Unmapped addresses get an error response, and hung slaves are caught by a watchdog that terminates the cycle with err. Two debug pulse outputs report decode errors and timeouts.

---
 rtl/wb_decoder_3_pkg.sv | 15 +
 rtl/wb_addr_match.sv | 24 ++
 rtl/wb_decoder_3.sv | 184 ++++++++++++++++++
 tb/tb_wb_decoder_3.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_decoder_3_pkg.sv
// Shared constants for the 3-slave Wishbone decoder: state encoding and error cause.
package wb_decoder_3_pkg;

  localparam int unsigned NumSlaves = 3;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StErr    = 2'd2;

  typedef enum logic {
    CauseDecode  = 1'b0,
    CauseTimeout = 1'b1
  } err_cause_e;

endpackage

// File: rtl/wb_addr_match.sv
// Combinational priority address comparator: lowest-index matching base wins.
module wb_addr_match #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NumPorts  = 3
) (
  input  logic [AddrWidth-1:0]               addr_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0] base_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0] mask_i,
  output logic [NumPorts-1:0]                hit_o,
  output logic                               valid_o
);

  always_comb begin
    hit_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (!valid_o && ((addr_i & mask_i[i]) == (base_i[i] & mask_i[i]))) begin
        hit_o[i] = 1'b1;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_decoder_3.sv
// Single-master to 3-slave Wishbone classic decoder with registered decode,
// unmapped-address error response and a watchdog for hung slaves.
module wb_decoder_3
  import wb_decoder_3_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0]  WBS0_ADDR      = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0]  WBS0_ADDR_MSK  = ADDR_WIDTH'(32'hFFFF_0000),
  parameter logic [ADDR_WIDTH-1:0]  WBS1_ADDR      = ADDR_WIDTH'(32'h0001_0000),
  parameter logic [ADDR_WIDTH-1:0]  WBS1_ADDR_MSK  = ADDR_WIDTH'(32'hFFFF_0000),
  parameter logic [ADDR_WIDTH-1:0]  WBS2_ADDR      = ADDR_WIDTH'(32'h8000_0000),
  parameter logic [ADDR_WIDTH-1:0]  WBS2_ADDR_MSK  = ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned            TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  input  logic                    wbm_cyc_i,

  output logic [ADDR_WIDTH-1:0]   wbs0_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs0_dat_o,
  output logic                    wbs0_we_o,
  output logic [SELECT_WIDTH-1:0] wbs0_sel_o,
  output logic                    wbs0_stb_o,
  input  logic                    wbs0_ack_i,
  input  logic                    wbs0_err_i,
  input  logic                    wbs0_rty_i,
  output logic                    wbs0_cyc_o,

  output logic [ADDR_WIDTH-1:0]   wbs1_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs1_dat_o,
  output logic                    wbs1_we_o,
  output logic [SELECT_WIDTH-1:0] wbs1_sel_o,
  output logic                    wbs1_stb_o,
  input  logic                    wbs1_ack_i,
  input  logic                    wbs1_err_i,
  input  logic                    wbs1_rty_i,
  output logic                    wbs1_cyc_o,

  output logic [ADDR_WIDTH-1:0]   wbs2_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs2_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs2_dat_o,
  output logic                    wbs2_we_o,
  output logic [SELECT_WIDTH-1:0] wbs2_sel_o,
  output logic                    wbs2_stb_o,
  input  logic                    wbs2_ack_i,
  input  logic                    wbs2_err_i,
  input  logic                    wbs2_rty_i,
  output logic                    wbs2_cyc_o,

  output logic                    decode_err_o,
  output logic                    timeout_o
);

  // A zero-cycle timeout still needs a 1-bit counter to keep the code legal.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]           state_q, state_d;
  logic [NumSlaves-1:0] sel_q, sel_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  err_cause_e           cause_q, cause_d;

  logic [NumSlaves-1:0]                 hit;
  logic                                 hit_valid;
  logic [NumSlaves-1:0]                 s_ack, s_err, s_rty;
  logic [NumSlaves-1:0][DATA_WIDTH-1:0] s_dat;
  logic [NumSlaves-1:0]                 cyc_gated, stb_gated;
  logic                                 active, sel_ack, sel_err, sel_rty, term;

  wb_addr_match #(
    .AddrWidth (ADDR_WIDTH),
    .NumPorts  (NumSlaves)
  ) u_addr_match (
    .addr_i  (wbm_adr_i),
    .base_i  ({WBS2_ADDR, WBS1_ADDR, WBS0_ADDR}),
    .mask_i  ({WBS2_ADDR_MSK, WBS1_ADDR_MSK, WBS0_ADDR_MSK}),
    .hit_o   (hit),
    .valid_o (hit_valid)
  );

  assign s_ack = {wbs2_ack_i, wbs1_ack_i, wbs0_ack_i};
  assign s_err = {wbs2_err_i, wbs1_err_i, wbs0_err_i};
  assign s_rty = {wbs2_rty_i, wbs1_rty_i, wbs0_rty_i};
  assign s_dat = {wbs2_dat_i, wbs1_dat_i, wbs0_dat_i};

  assign active  = (state_q == StActive);
  assign sel_ack = |(s_ack & sel_q);
  assign sel_err = |(s_err & sel_q);
  assign sel_rty = |(s_rty & sel_q);
  assign term    = sel_ack | sel_err | sel_rty;

  assign cyc_gated = {NumSlaves{active & wbm_cyc_i}} & sel_q;
  assign stb_gated = {NumSlaves{active & wbm_stb_i}} & sel_q;

  assign wbm_ack_o    = active & wbm_cyc_i & sel_ack;
  assign wbm_rty_o    = active & wbm_cyc_i & sel_rty;
  assign wbm_err_o    = (active & wbm_cyc_i & sel_err) | (state_q == StErr);
  assign decode_err_o = (state_q == StErr) && (cause_q == CauseDecode);
  assign timeout_o    = (state_q == StErr) && (cause_q == CauseTimeout);

  always_comb begin
    wbm_dat_o = '0;
    for (int unsigned i = 0; i < NumSlaves; i++) begin
      if (active && sel_q[i]) wbm_dat_o = s_dat[i];
    end
  end

  assign {wbs0_adr_o, wbs1_adr_o, wbs2_adr_o} = {3{wbm_adr_i}};
  assign {wbs0_dat_o, wbs1_dat_o, wbs2_dat_o} = {3{wbm_dat_i}};
  assign {wbs0_we_o, wbs1_we_o, wbs2_we_o}    = {3{wbm_we_i}};
  assign {wbs0_sel_o, wbs1_sel_o, wbs2_sel_o} = {3{wbm_sel_i}};
  assign {wbs2_cyc_o, wbs1_cyc_o, wbs0_cyc_o} = cyc_gated;
  assign {wbs2_stb_o, wbs1_stb_o, wbs0_stb_o} = stb_gated;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      StIdle: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (hit_valid) begin
            state_d = StActive;
            sel_d   = hit;
            cnt_d   = '0;
          end else begin
            state_d = StErr;
            cause_d = CauseDecode;
          end
        end
      end
      StActive: begin
        // Abort and termination both beat watchdog expiry.
        if (!wbm_cyc_i || term) begin
          state_d = StIdle;
          sel_d   = '0;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
          state_d = StErr;
          sel_d   = '0;
          cause_d = CauseTimeout;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
      cause_q <= CauseDecode;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_wb_decoder_3.sv
// Bench for wb_decoder_3: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_wb_decoder_3;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] adr;
  logic [DW-1:0] mdat;
  logic          we, stb, cyc;
  logic [SW-1:0] msel;
  logic [DW-1:0] s_dat [3];
  logic [2:0]    s_ack, s_err, s_rty;

  logic [DW-1:0] m_dat_o;
  logic          m_ack_o, m_err_o, m_rty_o, dec_o, to_o;
  logic [AW-1:0] o_adr [3];
  logic [DW-1:0] o_dat [3];
  logic [SW-1:0] o_sel [3];
  logic [2:0]    o_we, o_stb, o_cyc;

  int pass_cnt = 0;
  int total_cnt = 0;

  wb_decoder_3 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(adr), .wbm_dat_i(mdat), .wbm_dat_o(m_dat_o), .wbm_we_i(we),
    .wbm_sel_i(msel), .wbm_stb_i(stb), .wbm_ack_o(m_ack_o), .wbm_err_o(m_err_o),
    .wbm_rty_o(m_rty_o), .wbm_cyc_i(cyc),
    .wbs0_adr_o(o_adr[0]), .wbs0_dat_i(s_dat[0]), .wbs0_dat_o(o_dat[0]), .wbs0_we_o(o_we[0]),
    .wbs0_sel_o(o_sel[0]), .wbs0_stb_o(o_stb[0]), .wbs0_ack_i(s_ack[0]), .wbs0_err_i(s_err[0]),
    .wbs0_rty_i(s_rty[0]), .wbs0_cyc_o(o_cyc[0]),
    .wbs1_adr_o(o_adr[1]), .wbs1_dat_i(s_dat[1]), .wbs1_dat_o(o_dat[1]), .wbs1_we_o(o_we[1]),
    .wbs1_sel_o(o_sel[1]), .wbs1_stb_o(o_stb[1]), .wbs1_ack_i(s_ack[1]), .wbs1_err_i(s_err[1]),
    .wbs1_rty_i(s_rty[1]), .wbs1_cyc_o(o_cyc[1]),
    .wbs2_adr_o(o_adr[2]), .wbs2_dat_i(s_dat[2]), .wbs2_dat_o(o_dat[2]), .wbs2_we_o(o_we[2]),
    .wbs2_sel_o(o_sel[2]), .wbs2_stb_o(o_stb[2]), .wbs2_ack_i(s_ack[2]), .wbs2_err_i(s_err[2]),
    .wbs2_rty_i(s_rty[2]), .wbs2_cyc_o(o_cyc[2]),
    .decode_err_o(dec_o), .timeout_o(to_o)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  // Address map as plain data; first matching entry wins.
  logic [31:0] map_base [3] = '{32'h0000_0000, 32'h0001_0000, 32'h8000_0000};
  logic [31:0] map_mask [3] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'h8000_0000};

  function automatic int target_of(input logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if ((a & map_mask[i]) == (map_base[i] & map_mask[i])) return i;
    return -1;
  endfunction

  // Transaction-level model: what the decoder is doing in the current cycle.
  typedef enum int {MIdle, MServing, MErrReply} mphase_e;
  mphase_e m_phase = MIdle;
  int      m_tgt = 0;
  int      m_age = 0;
  bit      m_is_timeout = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_cyc", 64'(o_cyc), 64'd0);
      chk("rst_stb", 64'(o_stb), 64'd0);
      chk("rst_ack_err_rty", {61'd0, m_ack_o, m_err_o, m_rty_o}, 64'd0);
      chk("rst_pulses", {62'd0, dec_o, to_o}, 64'd0);
      chk("rst_dat", 64'(m_dat_o), 64'd0);
      m_phase = MIdle;
    end else begin
      bit serving;
      bit tgt_term;
      serving  = (m_phase == MServing);
      tgt_term = serving && (s_ack[m_tgt] || s_err[m_tgt] || s_rty[m_tgt]);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("adr%0d", i), 64'(o_adr[i]), 64'(adr));
        chk($sformatf("wdat%0d", i), 64'(o_dat[i]), 64'(mdat));
        chk($sformatf("we%0d", i), 64'(o_we[i]), 64'(we));
        chk($sformatf("sel%0d", i), 64'(o_sel[i]), 64'(msel));
        chk($sformatf("cyc%0d", i), 64'(o_cyc[i]), 64'(serving && cyc && m_tgt == i));
        chk($sformatf("stb%0d", i), 64'(o_stb[i]), 64'(serving && stb && m_tgt == i));
      end
      chk("ack", 64'(m_ack_o), 64'(serving && cyc && s_ack[m_tgt]));
      chk("rty", 64'(m_rty_o), 64'(serving && cyc && s_rty[m_tgt]));
      chk("err", 64'(m_err_o), 64'((serving && cyc && s_err[m_tgt]) || m_phase == MErrReply));
      chk("decode_err", 64'(dec_o), 64'(m_phase == MErrReply && !m_is_timeout));
      chk("timeout", 64'(to_o), 64'(m_phase == MErrReply && m_is_timeout));
      chk("rdat", 64'(m_dat_o), serving ? 64'(s_dat[m_tgt]) : 64'd0);
      case (m_phase)
        MIdle: if (cyc && stb) begin
          m_tgt = target_of(adr);
          if (m_tgt < 0) begin
            m_tgt = 0;
            m_phase = MErrReply;
            m_is_timeout = 0;
          end else begin
            m_phase = MServing;
            m_age = 0;
          end
        end
        MServing: begin
          m_age++;
          if (!cyc || tgt_term) m_phase = MIdle;
          else if (TO != 0 && m_age == TO) begin
            m_phase = MErrReply;
            m_is_timeout = 1;
          end
        end
        default: m_phase = MIdle;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 0; stb = 0; we = 0; adr = '0; mdat = '0; msel = '0;
  endtask

  task automatic slaves_quiet();
    s_ack = '0; s_err = '0; s_rty = '0;
  endtask

  task automatic req(input logic [31:0] a, input logic w);
    cyc = 1; stb = 1; adr = a; we = w; mdat = 32'hA5A5_0000 ^ a; msel = 4'hF;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return {16'h0000, 16'($urandom)};
      1: return {16'h0001, 16'($urandom)};
      2: return {1'b1, 31'($urandom)};
      3: return {16'h0002, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int rate;
    rst = 1;
    bus_idle();
    slaves_quiet();
    s_dat[0] = 32'h1111_0000; s_dat[1] = 32'h2222_0000; s_dat[2] = 32'h3333_0000;
    tick(); tick();
    chk("reset_ack", 64'(m_ack_o), 64'd0);
    chk("reset_dat", 64'(m_dat_o), 64'd0);
    rst = 0;
    tick();

    // Read from slave1, slave acks on its second strobe cycle.
    req(32'h0001_0004, 0);
    #3 chk("t1_T_stb1", 64'(o_stb[1]), 64'd0);
    tick();
    #3 chk("t1_T1_stb1", 64'(o_stb[1]), 64'd1);
    chk("t1_T1_ack", 64'(m_ack_o), 64'd0);
    chk("t1_T1_cyc02", 64'({o_cyc[2], o_cyc[0]}), 64'd0);
    tick();
    s_ack[1] = 1; s_dat[1] = 32'hDEAD_BEEF;
    #3 chk("t1_T2_stb1", 64'(o_stb[1]), 64'd1);
    chk("t1_T2_ack", 64'(m_ack_o), 64'd1);
    chk("t1_T2_dat", 64'(m_dat_o), 64'hDEAD_BEEF);
    tick();
    slaves_quiet(); bus_idle();
    #3 chk("t1_T3_stb1", 64'(o_stb[1]), 64'd0);
    chk("t1_T3_ack", 64'(m_ack_o), 64'd0);

    // Unmapped write.
    tick();
    req(32'h4000_0000, 1);
    tick();
    #3 chk("t2_T1_err", 64'(m_err_o), 64'd1);
    chk("t2_T1_dec", 64'(dec_o), 64'd1);
    chk("t2_T1_cyc", 64'(o_cyc), 64'd0);
    tick();
    bus_idle();
    #3 chk("t2_T2_err", 64'(m_err_o), 64'd0);
    chk("t2_T2_dec", 64'(dec_o), 64'd0);

    // Slave2 never answers: watchdog fires after TO cycles.
    tick();
    req(32'h8000_0010, 0);
    for (int k = 1; k <= TO; k++) begin
      tick();
      #3 chk($sformatf("t3_T%0d_stb2", k), 64'(o_stb[2]), 64'd1);
      chk($sformatf("t3_T%0d_err", k), 64'(m_err_o), 64'd0);
    end
    tick();
    #3 chk("t3_T5_err", 64'(m_err_o), 64'd1);
    chk("t3_T5_timeout", 64'(to_o), 64'd1);
    chk("t3_T5_cyc2", 64'(o_cyc[2]), 64'd0);
    chk("t3_T5_dec", 64'(dec_o), 64'd0);
    tick();
    bus_idle();
    #3 chk("t3_T6_timeout", 64'(to_o), 64'd0);

    // Retry on the cycle the watchdog would expire: termination wins.
    tick();
    req(32'h0000_0020, 0);
    for (int k = 1; k < TO; k++) begin
      tick();
      #3 chk($sformatf("t4_T%0d_cyc0", k), 64'(o_cyc[0]), 64'd1);
    end
    tick();
    s_rty[0] = 1;
    #3 chk("t4_T4_rty", 64'(m_rty_o), 64'd1);
    chk("t4_T4_err", 64'(m_err_o), 64'd0);
    chk("t4_T4_timeout", 64'(to_o), 64'd0);
    tick();
    slaves_quiet(); bus_idle();
    #3 chk("t4_T5_timeout", 64'(to_o), 64'd0);
    chk("t4_T5_err", 64'(m_err_o), 64'd0);

    // Master abort, then a fresh access to slave0.
    tick();
    req(32'h0001_0000, 0);
    tick();
    #3 chk("t5_T1_cyc1", 64'(o_cyc[1]), 64'd1);
    tick();
    cyc = 0; stb = 0;
    #3 chk("t5_T2_cyc1", 64'(o_cyc[1]), 64'd0);
    chk("t5_T2_err", 64'(m_err_o), 64'd0);
    tick();
    req(32'h0000_0000, 0);
    s_dat[0] = 32'hCAFE_0001;
    tick();
    s_ack[0] = 1;
    #3 chk("t5_T4_cyc0", 64'(o_cyc[0]), 64'd1);
    chk("t5_T4_cyc1", 64'(o_cyc[1]), 64'd0);
    chk("t5_T4_ack", 64'(m_ack_o), 64'd1);
    chk("t5_T4_dat", 64'(m_dat_o), 64'hCAFE_0001);
    tick();
    slaves_quiet(); bus_idle();

    // Reset in the middle of an active cycle.
    tick();
    req(32'h8000_0000, 0);
    tick();
    s_ack[2] = 1;
    #2 chk("t6_pre_ack", 64'(m_ack_o), 64'd1);
    rst = 1;
    #1 chk("t6_rst_cyc", 64'(o_cyc), 64'd0);
    chk("t6_rst_stb", 64'(o_stb), 64'd0);
    chk("t6_rst_ack_err", 64'({m_ack_o, m_err_o}), 64'd0);
    slaves_quiet(); bus_idle();
    @(negedge clk);
    #2 rst = 0;
    tick();
    req(32'h0001_0008, 0);
    s_dat[1] = 32'h0BAD_F00D;
    tick();
    s_ack[1] = 1;
    #3 chk("t6_post_ack", 64'(m_ack_o), 64'd1);
    chk("t6_post_dat", 64'(m_dat_o), 64'h0BAD_F00D);
    tick();
    slaves_quiet(); bus_idle();

    // Randomized traffic; termination rate varies to exercise the watchdog.
    rate = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 200 == 0) rate = (c / 200) % 3 == 0 ? 0 : ((c / 200) % 3 == 1 ? 8 : 35);
      cyc  = ($urandom_range(0, 7) != 0);
      stb  = ($urandom_range(0, 3) != 0);
      adr  = rand_addr();
      mdat = $urandom;
      we   = 1'($urandom);
      msel = 4'($urandom);
      for (int i = 0; i < 3; i++) begin
        s_dat[i] = $urandom;
        s_ack[i] = ($urandom_range(0, 99) < rate);
        s_err[i] = ($urandom_range(0, 99) < rate / 2);
        s_rty[i] = ($urandom_range(0, 99) < rate / 2);
      end
    end
    tick();
    bus_idle(); slaves_quiet();
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
